lvt_multiport_regfile: RTL
==========================

Name: lvt_multiport_regfile

Overview:
- Generalised multi-write-port integer register file built from one storage bank per write port, with a live-value table (LVT) selecting the most recent writer per register.
- Replaces the fixed commit-port plus accelerator-port bank arrangement with a single parametrised block, so any number of commit or accelerator writeback paths attach uniformly.
- Adds:
  - a post-reset zeroing sweep;
  - deterministic same-cycle write-conflict priority;
  - optional write-to-read bypass;
  - conflict reporting.

Parameters:
- WRITE_PORTS, 2, number of independent write ports (1..8); one bank per port.
- READ_PORTS, 2, number of combinational read ports (1..4).
- XLEN, 32, data width.
- NUM_REGS, 32, architectural registers (power of two, >=2); register 0 hardwired to zero.
- BYPASS, 0, 1 = read of a register being written this cycle returns the incoming write data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- ready  out  1  high once the zeroing sweep is complete; writes accepted only when high.
- wr_en[WRITE_PORTS]  in  1 each  write strobe per port.
- wr_addr[WRITE_PORTS]  in  $clog2(NUM_REGS) each  destination register.
- wr_data[WRITE_PORTS]  in  XLEN each  write data.
- rd_addr[READ_PORTS]  in  $clog2(NUM_REGS) each  source register.
- rd_data[READ_PORTS]  out  XLEN each  read data, combinational from rd_addr.
- write_conflict  out  1  registered pulse: previous cycle had two or more accepted writes to the same nonzero register.
- init_busy  out  1  high while the zeroing sweep runs (equals ~ready).

Behaviour:
- Clock and reset: one clock domain, clk; reset rst is synchronous and active-high.
- State machine: INIT, RUN.
- Reset:
  - rst high forces INIT, sweep counter = 0, ready = 0, init_busy = 1, write_conflict = 0.
  - Bank contents and LVT are not directly reset.
- INIT:
  - Each cycle writes zero to entry sweep counter in every bank and sets that LVT entry to 0; counter then increments.
  - After the entry NUM_REGS-1 write, next state is RUN.
  - Duration: exactly NUM_REGS cycles after rst deasserts, so ready rises on the NUM_REGS-th rising edge after the first edge with rst low.
  - rd_data = 0 for all ports during INIT. wr_en is ignored.
  - rst asserted mid-sweep restarts the sweep at counter 0.
- RUN:
  - ready = 1, init_busy = 0; stays in RUN until rst.
- Write acceptance: port p is accepted iff ready & wr_en[p] & (wr_addr[p] != 0).
- Accepted writes:
  - wr_data[p] is written into bank p at wr_addr[p].
  - The LVT entry for wr_addr[p] is set to p.
- Same-cycle conflict:
  - Multiple accepted writes to one address: the highest port index wins the LVT entry.
  - Losing banks still store their data but are never selected.
  - write_conflict is asserted the following cycle for exactly one cycle per conflicting cycle. Back-to-back conflicts keep it high.
- Reads:
  - rd_data[r] = bank[LVT[rd_addr[r]]][rd_addr[r]]; address 0 always reads 0; zero latency.
- Bypass:
  - BYPASS=0: a read in the same cycle as a write to that address returns the old value; the new value is visible from the next cycle.
  - BYPASS=1: returns wr_data of the highest-index accepted writer to that address this cycle.
- Widths: LVT entry width $clog2(WRITE_PORTS), minimum 1 bit. Sweep counter width $clog2(NUM_REGS)+1 so the terminal count is unambiguous.
- Writes to register 0 are dropped silently and never count as conflicts.

Test Plan:
- Reset then idle: rst high 3 cycles, then low. ready = 0 for 32 cycles, rises on the 32nd edge; every rd_addr reads 0x00000000 during and after the sweep.
- Single write: port 0 writes x5 = 0xDEADBEEF at cycle t. With BYPASS=0, a read of x5 at t gives 0, and at t+1 gives 0xDEADBEEF. With BYPASS=1, the read at t gives 0xDEADBEEF.
- LVT ordering: port 1 writes x7 = 0x11 at t, port 0 writes x7 = 0x22 at t+1. Read x7 gives 0x11 at t+1 and 0x22 at t+2 onward.
- Conflict: ports 0 and 1 both write x9 at t (0xAAAA, 0xBBBB). Reading x9 at t+1 gives 0xBBBB; write_conflict = 1 only at t+1. Same stimulus to x0 gives no conflict and x0 stays 0.
- x0 protection: all ports write x0 = 0xFFFFFFFF. Every read of x0 returns 0, and the LVT is unchanged.
- Reset mid-sweep: assert rst at sweep count 10, release. ready stays 0 for a full 32 cycles afterwards; writes issued during that window are ignored (target register reads 0 after ready).

Source files
------------

// File: rtl/lvt_multiport_regfile.sv
// lvt_multiport_regfile: multi-write-port register file, one bank per write port, live-value table picks the newest writer
module lvt_multiport_regfile #(
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 2,
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = 32,
  parameter int BYPASS      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        ready,
  input  logic [WRITE_PORTS-1:0]      wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr [WRITE_PORTS],
  input  logic [XLEN-1:0]             wr_data [WRITE_PORTS],
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr [READ_PORTS],
  output logic [XLEN-1:0]             rd_data [READ_PORTS],
  output logic                        write_conflict,
  output logic                        init_busy
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int LW = WRITE_PORTS > 1 ? $clog2(WRITE_PORTS) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [AW-1:0]         sweep_addr;
  logic                  sweep;
  logic                  conflict;
  logic [WRITE_PORTS-1:0] acc;
  logic [XLEN-1:0]       bank [WRITE_PORTS][NUM_REGS];
  logic [LW-1:0]         lvt [NUM_REGS];

  assign sweep_addr = cnt_q[AW-1:0];

  // state register; reset restarts the zeroing sweep
  always_ff @(posedge clk)
    state_q <= rst ? INIT : state_d;

  // leave INIT right after the last register has been cleared
  always_comb
    state_d = (state_q == INIT && cnt_q == CW'(NUM_REGS - 1)) ? RUN : state_q;

  // status outputs decoded from the state
  always_comb begin
    ready     = state_q == RUN;
    init_busy = state_q != RUN;
    sweep     = state_q == INIT;
  end

  // sweep counter walks every register once after reset
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : sweep ? cnt_q + 1'b1 : cnt_q;

  // a port writes only once ready and never to x0
  always_comb begin
    acc = '0;
    for (int p = 0; p < WRITE_PORTS; p++)
      acc[p] = ready & wr_en[p] & (wr_addr[p] != '0);
  end

  // flag any pair of accepted writes aimed at the same register
  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < WRITE_PORTS; p++)
      for (int q = p + 1; q < WRITE_PORTS; q++)
        if (acc[p] && acc[q] && wr_addr[p] == wr_addr[q])
          conflict = 1'b1;
  end

  // one-cycle conflict pulse following each conflicting cycle
  always_ff @(posedge clk)
    write_conflict <= rst ? 1'b0 : conflict;

  // every port owns a bank; losing writers still store but are never selected
  always_ff @(posedge clk)
    if (sweep)
      for (int p = 0; p < WRITE_PORTS; p++)
        bank[p][sweep_addr] <= '0;
    else
      for (int p = 0; p < WRITE_PORTS; p++)
        if (acc[p])
          bank[p][wr_addr[p]] <= wr_data[p];

  // live-value table; later loop iterations override so the highest port wins
  always_ff @(posedge clk)
    if (sweep)
      lvt[sweep_addr] <= '0;
    else
      for (int p = 0; p < WRITE_PORTS; p++)
        if (acc[p])
          lvt[wr_addr[p]] <= LW'(p);

  // combinational reads through the LVT, with optional forwarding of this cycle's writes
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      rd_data[r] = bank[lvt[rd_addr[r]]][rd_addr[r]];
      if (BYPASS != 0)
        for (int p = 0; p < WRITE_PORTS; p++)
          if (acc[p] && wr_addr[p] == rd_addr[r])
            rd_data[r] = wr_data[p];
      if (!ready || rd_addr[r] == '0)
        rd_data[r] = '0;
    end
  end
endmodule
